frequency_generator: RTL and testbench

- Transmit-side companion to the frequency counter: produces a square-wave test signal with exactly N rising edges per counting window (N = 0..99).
- N is programmed as two BCD digits, the same tens/units form the counter displays.
- Drives the counter's signal input for loopback self-test.
- A registered accumulator spreads the edges evenly across the window.

---
 rtl/frequency_generator.sv | 159 +++++++++++++++
 tb/tb_frequency_generator.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_generator.sv
// frequency_generator
//
// Produces a square wave with exactly N rising edges per counting window of
// UPDATE_PERIOD clk cycles, N = 0..99 programmed as two BCD digits. Intended
// as a loopback stimulus for the frequency counter.
//
// A phase accumulator adds 2*N each cycle and toggles the output every time it
// crosses UPDATE_PERIOD, so the 2N toggles are spread evenly over the window
// and the accumulator lands back on zero at the window end.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tens, units  BCD digits of the requested edge count (digits >9 clamp to 9)
//   load         one-cycle capture request, ignored while busy
//   enable       1 = generate windows, 0 = idle with output low
//   signal_out   generated square wave (registered)
//   busy         BCD-to-binary conversion in progress
//   window_start one-cycle pulse in the cycle after window cycle 0
//   edge_count   edge count N currently in effect
module frequency_generator #(
    parameter int unsigned UPDATE_PERIOD = 1200,
    parameter int unsigned BITS          = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       load,
    input  logic       enable,
    output logic       signal_out,
    output logic       busy,
    output logic       window_start,
    output logic [6:0] edge_count
);

    localparam logic [BITS-1:0] LAST_CNT   = BITS'(UPDATE_PERIOD - 1);
    localparam logic [BITS:0]   PERIOD_EXT = (BITS + 1)'(UPDATE_PERIOD);

    typedef enum logic [0:0] {StIdle, StConv} conv_state_e;

    // Conversion state
    conv_state_e state_q, state_d;
    logic [6:0]  conv_acc_q, conv_acc_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [6:0]  next_count_q, next_count_d;
    logic        pending_q, pending_d;
    logic        conv_done;
    logic [3:0]  tens_c, units_c;

    // Window / tone state
    logic [BITS-1:0] win_cnt_q;
    logic [BITS-1:0] acc_q, acc_d;
    logic            at_start;
    logic [6:0]      count_eff;
    logic [BITS:0]   base, step, sum;
    logic            toggle;

    assign tens_c   = (tens > 4'd9) ? 4'd9 : tens;
    assign units_c  = (units > 4'd9) ? 4'd9 : units;
    assign busy     = (state_q == StConv);
    assign at_start = (win_cnt_q == '0);

    // ------------------------------------------------------------------
    // BCD conversion: units + 10*tens by repeated addition, one step/cycle
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        conv_acc_d   = conv_acc_q;
        remaining_d  = remaining_q;
        conv_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d     = StConv;
                    conv_acc_d  = {3'b000, units_c};
                    remaining_d = tens_c;
                end
            end
            StConv: begin
                if (remaining_q != 4'd0) begin
                    conv_acc_d  = conv_acc_q + 7'd10;
                    remaining_d = remaining_q - 4'd1;
                end else begin
                    conv_done = 1'b1;
                    state_d   = StIdle;
                end
            end
        endcase

        next_count_d = conv_done ? conv_acc_q : next_count_q;

        // A conversion finishing on the boundary cycle must survive the clear,
        // so the set is applied after it.
        pending_d = pending_q;
        if (enable && at_start) begin
            pending_d = 1'b0;
        end
        if (conv_done) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            conv_acc_q   <= '0;
            remaining_q  <= '0;
            next_count_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_acc_q   <= conv_acc_d;
            remaining_q  <= remaining_d;
            next_count_q <= next_count_d;
            pending_q    <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Phase accumulator
    // ------------------------------------------------------------------
    always_comb begin
        // A staged count is picked up only on window cycle 0, so the whole
        // window runs at a single rate.
        count_eff = (at_start && pending_q) ? next_count_q : edge_count;
        // Any residue at cycle 0 is dropped so every window starts in phase.
        base      = at_start ? '0 : {1'b0, acc_q};
        step      = (BITS + 1)'({count_eff, 1'b0});
        sum       = base + step;
        toggle    = (sum >= PERIOD_EXT);
        acc_d     = toggle ? BITS'(sum - PERIOD_EXT) : sum[BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt_q    <= '0;
            acc_q        <= '0;
            signal_out   <= 1'b0;
            window_start <= 1'b0;
            edge_count   <= '0;
        end else if (!enable) begin
            win_cnt_q    <= '0;
            acc_q        <= '0;
            signal_out   <= 1'b0;
            window_start <= 1'b0;
        end else begin
            win_cnt_q    <= (win_cnt_q == LAST_CNT) ? '0 : win_cnt_q + 1'b1;
            acc_q        <= acc_d;
            // Forced low at cycle 0 so a window never inherits a stale level.
            signal_out   <= at_start ? toggle : (signal_out ^ toggle);
            window_start <= at_start;
            if (at_start) begin
                edge_count <= count_eff;
            end
        end
    end

endmodule

// File: tb/tb_frequency_generator.sv
module tb_frequency_generator;

    localparam int P = 1200;

    logic       clk;
    logic       reset;
    logic [3:0] tens;
    logic [3:0] units;
    logic       load;
    logic       enable;
    logic       signal_out;
    logic       busy;
    logic       window_start;
    logic [6:0] edge_count;

    int tests = 0;
    int fails = 0;

    // Reference model state (values seen in the current cycle)
    int m_pos   = 0;   // cycles since window start
    int m_n     = 0;   // edge count in effect
    int m_st    = 0;   // staged count
    bit m_stv   = 0;   // staged count waiting for a boundary
    int m_bl    = 0;   // busy cycles still to come
    int m_cv    = 0;   // value the running conversion will produce
    bit m_sig   = 0;
    bit m_ws    = 0;

    frequency_generator #(
        .UPDATE_PERIOD(P),
        .BITS(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tens(tens),
        .units(units),
        .load(load),
        .enable(enable),
        .signal_out(signal_out),
        .busy(busy),
        .window_start(window_start),
        .edge_count(edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec();
        logic [6:0] n;
        n = 7'(m_n);
        return {m_sig, (m_bl > 0), m_ws, n};
    endfunction

    // One clock; the model advances from the inputs that were presented.
    task automatic tick();
        bit r, e, l;
        int t, u, ct, cu;
        r = reset; e = enable; l = load; t = int'(tens); u = int'(units);
        @(posedge clk);
        #1;
        if (r) begin
            m_pos = 0; m_n = 0; m_st = 0; m_stv = 0; m_bl = 0; m_cv = 0;
            m_sig = 0; m_ws = 0;
        end else begin
            if (e) begin
                m_ws = (m_pos == 0);
                if (m_pos == 0) begin
                    if (m_stv) m_n = m_st;
                    m_stv = 0;
                end
                m_pos = (m_pos + 1) % P;
                // Level at window position j = parity of toggles so far,
                // toggles so far = floor(2N*j/P).
                m_sig = (m_pos == 0) ? 1'b0 : 1'(((2 * m_n * m_pos) / P) % 2);
            end else begin
                m_pos = 0; m_sig = 0; m_ws = 0;
            end
            if (m_bl > 0) begin
                m_bl--;
                if (m_bl == 0) begin
                    m_st = m_cv; m_stv = 1;
                end
            end else if (l) begin
                ct = (t > 9) ? 9 : t;
                cu = (u > 9) ? 9 : u;
                m_bl = ct + 1;
                m_cv = 10 * ct + cu;
            end
        end
    endtask

    // Runs cycles and gathers statistics; callers make the comparisons.
    task automatic observe(input int cycles, input int n_sel, input bit pulse,
                           output int vmis, output int busy_c, output int wins,
                           output int bad, output int first_rise, output int min_w,
                           output int ws_hi);
        int rises, cur_n, run;
        bit cur_valid, run_valid;
        logic prev_sig;
        rises = 0; cur_n = -1; run = 0; cur_valid = 0; run_valid = 0;
        vmis = 0; busy_c = 0; wins = 0; bad = 0; first_rise = -1; min_w = 1 << 30;
        ws_hi = 0;
        prev_sig = signal_out;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (pulse && i == 0) load = 1'b0;
            if ({signal_out, busy, window_start, edge_count} !== exp_vec()) begin
                if (vmis == 0)
                    $display("[TB] divergence t=%0t dut=%b model=%b", $time,
                             {signal_out, busy, window_start, edge_count}, exp_vec());
                vmis++;
            end
            if (busy === 1'b1) busy_c++;
            if (m_ws) begin
                if (signal_out !== 1'b0) ws_hi++;
                if (cur_valid && cur_n == n_sel) begin
                    wins++;
                    if (rises != n_sel) bad++;
                end
                rises = 0; cur_n = m_n; cur_valid = 1;
            end
            if (signal_out !== prev_sig) begin
                if (run_valid && cur_n == n_sel && run < min_w) min_w = run;
                run = 1; run_valid = 1;
            end else begin
                run++;
            end
            if (signal_out === 1'b1 && prev_sig === 1'b0) begin
                rises++;
                if (rises == 1 && cur_valid && cur_n == n_sel && first_rise < 0)
                    first_rise = m_pos;
            end
            prev_sig = signal_out;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1;
        tens = 4'($urandom_range(0, 15)); units = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({signal_out, busy, window_start, edge_count} !== 10'b0) begin
                fails++;
                $display("FAIL reset_state cycle %0d: got %b want 0", i,
                         {signal_out, busy, window_start, edge_count});
            end
        end
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        tick();
    endtask

    task automatic test_idle_windows();
        int vmis, bc, wins, bad, fr, mw, wh;
        enable = 1'b1;
        observe(3 * P, 0, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        tests++;
        if (vmis !== 0) begin
            fails++; $display("FAIL idle_model: %0d divergent cycles, want 0", vmis);
        end
        tests++;
        if (wins !== 2 || bad !== 0) begin
            fails++; $display("FAIL idle_windows: %0d windows %0d bad, want 2 and 0", wins, bad);
        end
        tests++;
        if (edge_count !== 7'd0) begin
            fails++; $display("FAIL idle_count: got %0d want 0", edge_count);
        end
    endtask

    task automatic test_load_25();
        int vmis, bc, wins, bad, fr, mw, wh;
        tens = 4'd2; units = 4'd5; load = 1'b1;
        observe(3 * P, 25, 1'b1, vmis, bc, wins, bad, fr, mw, wh);
        tests++;
        if (vmis !== 0) begin
            fails++; $display("FAIL n25_model: %0d divergent cycles, want 0", vmis);
        end
        tests++;
        if (bc !== 3) begin
            fails++; $display("FAIL n25_busy: got %0d cycles want 3", bc);
        end
        tests++;
        if (wins < 1 || bad !== 0) begin
            fails++; $display("FAIL n25_edges: %0d windows %0d bad, want >=1 and 0", wins, bad);
        end
        tests++;
        if (fr !== 24) begin
            fails++; $display("FAIL n25_first_rise: got %0d want 24", fr);
        end
        tests++;
        if (edge_count !== 7'd25) begin
            fails++; $display("FAIL n25_count: got %0d want 25", edge_count);
        end
    endtask

    task automatic test_clamp_99();
        int vmis, bc, wins, bad, fr, mw, wh;
        int v1, b1, v2, b2;
        tens = 4'd12; units = 4'd15; load = 1'b1;
        observe(5, 99, 1'b1, v1, b1, wins, bad, fr, mw, wh);
        tens = 4'd3; units = 4'd3; load = 1'b1;   // must be ignored
        observe(1, 99, 1'b1, v2, b2, wins, bad, fr, mw, wh);
        observe(3 * P, 99, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        tests++;
        if (vmis + v1 + v2 !== 0) begin
            fails++; $display("FAIL n99_model: %0d divergent cycles, want 0", vmis + v1 + v2);
        end
        tests++;
        if (b1 + b2 + bc !== 10) begin
            fails++; $display("FAIL n99_busy: got %0d cycles want 10", b1 + b2 + bc);
        end
        tests++;
        if (wins < 1 || bad !== 0) begin
            fails++; $display("FAIL n99_edges: %0d windows %0d bad, want >=1 and 0", wins, bad);
        end
        tests++;
        if (mw < 6) begin
            fails++; $display("FAIL n99_min_width: got %0d want >=6", mw);
        end
        tests++;
        if (wh !== 0) begin
            fails++; $display("FAIL n99_low_at_start: %0d high samples, want 0", wh);
        end
        tests++;
        if (edge_count !== 7'd99) begin
            fails++; $display("FAIL n99_count: got %0d want 99", edge_count);
        end
    endtask

    task automatic test_mid_window_change();
        int vmis, bc, wins, bad, fr, mw, wh, acc_mis;
        acc_mis = 0;
        tens = 4'd2; units = 4'd5; load = 1'b1;
        observe(2 * P, -1, 1'b1, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        observe((600 - m_pos + P) % P, -1, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tens = 4'd0; units = 4'd7; load = 1'b1;
        observe(P - m_pos, -1, 1'b1, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tests++;
        if (edge_count !== 7'd25) begin
            fails++; $display("FAIL mid_old_count: got %0d want 25 at boundary", edge_count);
        end
        observe(1, -1, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tests++;
        if (edge_count !== 7'd7) begin
            fails++; $display("FAIL mid_new_count: got %0d want 7", edge_count);
        end
        observe(2 * P + 10, 7, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tests++;
        if (wins < 1 || bad !== 0) begin
            fails++; $display("FAIL mid_n7_edges: %0d windows %0d bad, want >=1 and 0", wins, bad);
        end
        tests++;
        if (acc_mis !== 0) begin
            fails++; $display("FAIL mid_model: %0d divergent cycles, want 0", acc_mis);
        end
    endtask

    task automatic test_random();
        int vmis, bc, wins, bad, fr, mw, wh;
        bit pulse;
        for (int it = 0; it < 20; it++) begin
            enable = ($urandom_range(0, 3) != 0);
            pulse = 1'($urandom_range(0, 1));
            if (pulse) begin
                tens = 4'($urandom_range(0, 15));
                units = 4'($urandom_range(0, 15));
                load = 1'b1;
            end
            observe($urandom_range(5, 1500), -1, pulse, vmis, bc, wins, bad, fr, mw, wh);
            tests++;
            if (vmis !== 0) begin
                fails++; $display("FAIL random_%0d: %0d divergent cycles, want 0", it, vmis);
            end
        end
    endtask

    task automatic test_reset_mid();
        int vmis, bc, wins, bad, fr, mw, wh, acc_mis;
        acc_mis = 0;
        enable = 1'b1; tens = 4'd2; units = 4'd5; load = 1'b1;
        observe(2 * P, -1, 1'b1, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        observe((295 - m_pos + P) % P, -1, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tens = 4'd9; units = 4'd9; load = 1'b1;
        observe(5, -1, 1'b1, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tests++;
        if (busy !== 1'b1 || m_pos != 300) begin
            fails++; $display("FAIL rst_setup: busy=%b pos=%0d want 1 and 300", busy, m_pos);
        end
        reset = 1'b1;
        observe(1, -1, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        reset = 1'b0;
        tests++;
        if ({signal_out, busy, window_start, edge_count} !== 10'b0) begin
            fails++; $display("FAIL rst_mid_outputs: got %b want 0",
                              {signal_out, busy, window_start, edge_count});
        end
        observe(2 * P + 5, 0, 1'b0, vmis, bc, wins, bad, fr, mw, wh);
        acc_mis += vmis;
        tests++;
        if (edge_count !== 7'd0 || wins < 1 || bad !== 0) begin
            fails++; $display("FAIL rst_after: count=%0d windows=%0d bad=%0d want 0,>=1,0",
                              edge_count, wins, bad);
        end
        tests++;
        if (acc_mis !== 0) begin
            fails++; $display("FAIL rst_model: %0d divergent cycles, want 0", acc_mis);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; tens = 4'd0; units = 4'd0;
        test_reset();
        test_idle_windows();
        test_load_25();
        test_clamp_99();
        test_mid_window_change();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
